// File: rtl/led_flick_sequencer_pkg.sv
// Shared encodings, widths and count limits for the LED flick sequencer.
// The thermometer helper is used by the top to build the LED bar.
package led_flick_sequencer_pkg;

    localparam int COUNT_W = 5;
    localparam int LED_W   = 15;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_UP15      = 3'd1,
        ST_DOWN5     = 3'd2,
        ST_UP10      = 3'd3,
        ST_DOWN0     = 3'd4,
        ST_UP5       = 3'd5,
        ST_DOWN0_END = 3'd6
    } seq_state_t;

    localparam logic [COUNT_W-1:0] CNT_MAX  = 5'd15;
    localparam logic [COUNT_W-1:0] CNT_TEN  = 5'd10;
    localparam logic [COUNT_W-1:0] CNT_FIVE = 5'd5;
    localparam logic [COUNT_W-1:0] CNT_FOUR = 5'd4;
    localparam logic [COUNT_W-1:0] CNT_ONE  = 5'd1;
    localparam logic [COUNT_W-1:0] CNT_ZERO = 5'd0;

    function automatic logic [LED_W-1:0] thermometer(input logic [COUNT_W-1:0] level);
        logic [LED_W-1:0] bar;
        bar = '0;
        for (int unsigned i = 0; i < LED_W; i++) begin
            bar[i] = (i < 32'(level));
        end
        return bar;
    endfunction

endpackage

// File: rtl/led_flick_next_step.sv
// Pure next-step decode of the brightness sequence: given the current state,
// count and pending request, produce the values to load on the next tick.
module led_flick_next_step
    import led_flick_sequencer_pkg::*;
(
    input  logic               f,
    input  logic [COUNT_W-1:0] count,
    input  seq_state_t         state,
    output logic [COUNT_W-1:0] next_count,
    output seq_state_t         next_state,
    output logic               decision
);

    logic at_turn;

    always_comb begin
        next_state = state;
        next_count = count;
        decision   = 1'b0;
        at_turn    = (count == CNT_FOUR) || (count == CNT_ZERO);
        case (state)
            ST_IDLE: begin
                decision = 1'b1;
                if (f) begin
                    next_state = ST_UP15;
                    next_count = CNT_ONE;
                end else begin
                    next_count = CNT_ZERO;
                end
            end
            ST_UP15: begin
                if (count < CNT_MAX) begin
                    next_count = count + CNT_ONE;
                end else begin
                    next_state = ST_DOWN5;
                    next_count = CNT_MAX - CNT_ONE;
                end
            end
            ST_DOWN5: begin
                if (count != CNT_FOUR) begin
                    next_count = count - CNT_ONE;
                end else begin
                    decision   = 1'b1;
                    next_state = f ? ST_UP15 : ST_UP10;
                    next_count = CNT_FIVE;
                end
            end
            ST_UP10: begin
                if (count != CNT_TEN) begin
                    next_count = count + CNT_ONE;
                end else begin
                    next_state = ST_DOWN0;
                    next_count = CNT_TEN - CNT_ONE;
                end
            end
            ST_DOWN0: begin
                // Both count 4 and count 0 are decision points; only 0 can fall through to UP5.
                decision = at_turn;
                if (at_turn && f) begin
                    next_state = ST_UP10;
                    next_count = count + CNT_ONE;
                end else if (count == CNT_ZERO) begin
                    next_state = ST_UP5;
                    next_count = CNT_ONE;
                end else begin
                    next_count = count - CNT_ONE;
                end
            end
            ST_UP5: begin
                if (count != CNT_FIVE) begin
                    next_count = count + CNT_ONE;
                end else begin
                    next_state = ST_DOWN0_END;
                    next_count = CNT_FOUR;
                end
            end
            ST_DOWN0_END: begin
                if (count != CNT_ZERO) begin
                    next_count = count - CNT_ONE;
                end else begin
                    next_state = ST_IDLE;
                    next_count = CNT_ZERO;
                end
            end
            default: begin
                next_state = ST_IDLE;
                next_count = CNT_ZERO;
            end
        endcase
    end

endmodule

// File: rtl/led_flick_sequencer.sv
// Button-triggered LED bar sequencer: synchronizes flick requests, divides the
// clock into sequence steps and walks the brightness pattern one step per tick.
module led_flick_sequencer
    import led_flick_sequencer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 25_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               flick,
    output logic [LED_W-1:0]   led,
    output logic [2:0]         state,
    output logic [COUNT_W-1:0] count,
    output logic               busy,
    output logic               done
);

    localparam int unsigned         PRESC_W    = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [PRESC_W-1:0]  PRESC_ONE  = PRESC_W'(1);

    logic [1:0]         sync;
    logic               sync_prev;
    logic               sync_rise;
    logic               flick_pending;
    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic               f;
    seq_state_t         cur_state;
    logic [COUNT_W-1:0] cur_count;
    seq_state_t         next_state;
    logic [COUNT_W-1:0] next_count;
    logic               decision;

    assign sync_rise = sync[1] & ~sync_prev;
    assign tick      = enable && (presc == PRESC_LAST);
    // A rise landing on the deciding tick counts immediately and also stays pending.
    assign f         = flick_pending | sync_rise;

    led_flick_next_step u_next_step (
        .f          (f),
        .count      (cur_count),
        .state      (cur_state),
        .next_count (next_count),
        .next_state (next_state),
        .decision   (decision)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync          <= '0;
            sync_prev     <= 1'b0;
            flick_pending <= 1'b0;
            presc         <= '0;
        end else begin
            sync      <= {sync[0], flick};
            sync_prev <= sync[1];
            if (sync_rise) begin
                flick_pending <= 1'b1;
            end else if (tick && decision) begin
                flick_pending <= 1'b0;
            end
            if (enable) begin
                presc <= (presc == PRESC_LAST) ? '0 : presc + PRESC_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= ST_IDLE;
            cur_count <= '0;
            done      <= 1'b0;
        end else begin
            done <= tick && (cur_state == ST_DOWN0_END) && (cur_count == CNT_ZERO);
            if (tick) begin
                cur_state <= next_state;
                cur_count <= next_count;
            end
        end
    end

    assign state = cur_state;
    assign count = cur_count;
    assign busy  = (cur_state != ST_IDLE);
    assign led   = thermometer(cur_count);

endmodule

// File: tb/tb_led_flick_sequencer.sv
// Self-checking bench for led_flick_sequencer: table-driven reference model
// compared every cycle, directed scenarios with literal expectations, then random traffic.
module tb_led_flick_sequencer;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        flick = 1'b0;
    logic [14:0] led;
    logic [2:0]  state;
    logic [4:0]  count;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    led_flick_sequencer #(.TICK_DIV(TD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .flick  (flick),
        .led    (led),
        .state  (state),
        .count  (count),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Reference model: sequence as a table of segments (direction, end count, exits).
    int dir_t   [7] = '{0, 1, -1, 1, -1, 1, -1};
    int lim_t   [7] = '{0, 15, 4, 10, 0, 5, 0};
    int exit_nf [7] = '{0, 2, 3, 4, 5, 6, 0};
    int exit_f  [7] = '{1, 2, 1, 4, 3, 6, 0};
    int exit_c  [7] = '{0, 14, 5, 9, 1, 4, 0};

    int m_state = 0, m_count = 0, m_presc = 0;
    bit m_s1 = 0, m_s2 = 0, m_s2d = 0, m_pend = 0, m_done = 0;

    task automatic model_reset();
        m_state = 0; m_count = 0; m_presc = 0;
        m_s1 = 0; m_s2 = 0; m_s2d = 0; m_pend = 0; m_done = 0;
    endtask

    task automatic model_step();
        bit rise, tk, fl, dec;
        int ns, nc;
        rise = m_s2 && !m_s2d;
        tk   = enable && (m_presc == TD - 1);
        fl   = m_pend || rise;
        m_done = 1'b0;
        if (tk) begin
            dec = (m_state == 0) || (m_state == 2 && m_count == 4) ||
                  (m_state == 4 && (m_count == 4 || m_count == 0));
            if (m_state > 6) begin
                ns = 0; nc = 0;
            end else if (m_state == 0) begin
                ns = fl ? 1 : 0; nc = fl ? 1 : 0;
            end else if (m_state == 4 && m_count == 4 && fl) begin
                ns = 3; nc = 5;
            end else if (m_count == lim_t[m_state]) begin
                ns = fl ? exit_f[m_state] : exit_nf[m_state];
                nc = exit_c[m_state];
            end else begin
                ns = m_state; nc = m_count + dir_t[m_state];
            end
            m_done = (m_state == 6 && m_count == 0);
            if (dec) m_pend = 1'b0;
            m_state = ns; m_count = nc;
        end
        if (rise) m_pend = 1'b1;
        if (enable) m_presc = (m_presc == TD - 1) ? 0 : m_presc + 1;
        m_s2d = m_s2; m_s2 = m_s1; m_s1 = flick;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    always begin
        @(negedge clk);
        #1;
        check("cyc_state", int'(state), m_state);
        check("cyc_count", int'(count), m_count);
        check("cyc_led",   int'(led),   (1 << m_count) - 1);
        check("cyc_busy",  int'(busy),  int'(m_state != 0));
        check("cyc_done",  int'(done),  int'(m_done));
    end

    task automatic wait_for(input int st, input int cnt, input string name);
        int n = 0;
        while (!(int'(state) == st && int'(count) == cnt) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 2000) begin
            bad++;
            $display("FAIL %s: timeout got state %0d count %0d want state %0d count %0d",
                     name, state, count, st, cnt);
        end
    endtask

    // Flick rises right at reset release so its synchronized edge lands mid-step.
    task automatic start_from_reset();
        @(negedge clk);
        rst_n = 1'b0; enable = 1'b1; flick = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; flick = 1'b1;
        repeat (3) @(negedge clk);
        flick = 1'b0;
    endtask

    task automatic check_sc(input string name, input int st, input int cnt);
        check({name, "_state"}, int'(state), st);
        check({name, "_count"}, int'(count), cnt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, pulses, at;

        repeat (3) @(negedge clk);
        check("rst_state", int'(state), 0);
        check("rst_count", int'(count), 0);
        check("rst_led",   int'(led),   0);
        check("rst_busy",  int'(busy),  0);
        check("rst_done",  int'(done),  0);

        // Single flick: full sequence and done timing
        start_from_reset();
        wait_for(1, 1, "a_tick1");
        check_sc("a_tick1", 1, 1);
        check("a_tick1_led", int'(led), 32'h0001);
        check("a_model_tick1", m_count, 1);
        check("a_pend_cleared", int'(m_pend), 0);
        cyc = 0;
        repeat (14 * TD) @(negedge clk);
        cyc += 14 * TD;
        check_sc("a_tick15", 1, 15);
        check("a_tick15_led", int'(led), 32'h7FFF);
        repeat (TD) @(negedge clk);
        cyc += TD;
        check_sc("a_tick16", 2, 14);
        pulses = 0; at = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                pulses++;
                if (at < 0) begin
                    at = cyc;
                    check_sc("a_done", 0, 0);
                    check("a_done_busy", int'(busy), 0);
                end
            end
        end
        check("a_done_cycle", at, 52 * TD);
        check("a_done_pulses", pulses, 1);

        // Decision points with pending flicks, freeze, re-arm at DOWN0
        start_from_reset();
        wait_for(1, 1, "b_start");
        wait_for(2, 4, "b_down5_a");
        flick = 1'b1;
        repeat (3) @(negedge clk);
        flick = 1'b0;
        @(negedge clk);
        check_sc("b_reup15", 1, 5);
        check("b_pend_used", int'(m_pend), 0);

        wait_for(2, 4, "b_down5_b");
        @(negedge clk);
        flick = 1'b1;
        repeat (3) @(negedge clk);
        check_sc("b_coinc", 1, 5);
        check("b_pend_kept", int'(m_pend), 1);
        flick = 1'b0;

        wait_for(2, 4, "b_down5_c");
        repeat (TD) @(negedge clk);
        check_sc("b_consume", 1, 5);
        check("b_pend_gone", int'(m_pend), 0);

        wait_for(2, 4, "b_down5_d");
        repeat (TD) @(negedge clk);
        check_sc("b_to_up10", 3, 5);

        wait_for(3, 7, "b_up10_7");
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_sc("b_frozen", 3, 7);
            check("b_frozen_led", int'(led), 32'h007F);
        end
        enable = 1'b1;
        repeat (TD - 1) @(negedge clk);
        check_sc("b_resume_wait", 3, 7);
        @(negedge clk);
        check_sc("b_resume", 3, 8);

        wait_for(4, 1, "b_down0_1");
        flick = 1'b1;
        repeat (3) @(negedge clk);
        flick = 1'b0;
        @(negedge clk);
        check_sc("b_down0_0", 4, 0);
        repeat (TD) @(negedge clk);
        check_sc("b_down0_up10", 3, 1);

        // Reset mid-UP15
        start_from_reset();
        wait_for(1, 5, "c_up15");
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("c_rst_state", int'(state), 0);
        check("c_rst_count", int'(count), 0);
        check("c_rst_led",   int'(led),   0);
        check("c_rst_busy",  int'(busy),  0);
        check("c_rst_done",  int'(done),  0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check_sc("c_idle_after", 0, 0);
        check("c_idle_busy", int'(busy), 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) flick = ~flick;
            enable = ($urandom_range(0, 7) != 0);
            rst_n  = ($urandom_range(0, 599) != 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
